// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Fixed-latency single-port data memory responder. Each request (exactly one
//   of load/store) is accepted in IDLE and completes LATENCY cycles later with
//   a one-cycle mem_in_done pulse. When both flags are high in IDLE, nothing is
//   accepted and mem_err pulses instead.
//
//   Optional build macro DATA_MEM_RESPONDER_RANGE_CHECK_EN:
//     defined   - addresses >= DEPTH complete normally, but they never write,
//                 a load returns 0, and mem_err pulses with mem_in_done.
//     undefined - the address is taken modulo DEPTH.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset (state, outputs, array)
//   out_1_mem_addr in   [ADDR_W] request word address
//   out_1_mem_data in   [DATA_W] store data
//   out_load_flag  in   load request
//   out_store_flag in   store request
//   load_data      out  [DATA_W] last load result, held until the next load
//   mem_in_done    out  one-cycle completion pulse
//   mem_busy       out  high in WAIT and DONE
//   mem_err        out  one-cycle error pulse
module data_mem_responder #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] out_1_mem_addr,
  input  logic [DATA_W-1:0] out_1_mem_data,
  input  logic              out_load_flag,
  input  logic              out_store_flag,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_in_done,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MEM_WORDS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_idx;
  logic              r_oor;
  logic              r_is_load;
  logic [DATA_W-1:0] r_load_data;
  logic              r_err, w_err_next;
  // Sized to the full address space so any index is legal; words at DEPTH
  // and above are never written and stay constant zero.
  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic              w_req_one, w_req_both, w_accept, w_enter_done;
  logic [ADDR_W-1:0] w_in_idx, w_rd_idx;
  logic              w_in_oor, w_rd_oor, w_rd_load;

  assign w_req_one  = out_load_flag ^ out_store_flag;
  assign w_req_both = out_load_flag & out_store_flag;
  assign w_accept   = (r_state == IDLE) && w_req_one;
  assign w_in_idx   = ADDR_W'({1'b0, out_1_mem_addr} % DEPTH_L);

`ifdef DATA_MEM_RESPONDER_RANGE_CHECK_EN
  assign w_in_oor = ({1'b0, out_1_mem_addr} >= DEPTH_L);
`else
  assign w_in_oor = 1'b0;
`endif

  // With LATENCY=1, DONE is entered straight from IDLE at the accept edge,
  // so the read must use the live request rather than the captured one.
  assign w_rd_idx  = (r_state == IDLE) ? w_in_idx      : r_idx;
  assign w_rd_oor  = (r_state == IDLE) ? w_in_oor      : r_oor;
  assign w_rd_load = (r_state == IDLE) ? out_load_flag : r_is_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_err_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_one) begin
          w_cnt_next = CNT_INIT;
          w_next     = (LATENCY == 1) ? DONE : WAIT;
        end else if (w_req_both) begin
          w_err_next = 1'b1;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_enter_done = (w_next == DONE) && (r_state != DONE);
    if (w_enter_done && w_rd_oor) w_err_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_oor       <= 1'b0;
      r_is_load   <= 1'b0;
      r_load_data <= '0;
      r_err       <= 1'b0;
      for (int unsigned i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      r_err <= w_err_next;
      if (w_accept) begin
        r_idx     <= w_in_idx;
        r_oor     <= w_in_oor;
        r_is_load <= out_load_flag;
        if (out_store_flag && !w_in_oor) r_mem[w_in_idx] <= out_1_mem_data;
      end
      if (w_enter_done && w_rd_load)
        r_load_data <= w_rd_oor ? '0 : r_mem[w_rd_idx];
    end
  end

  assign load_data   = r_load_data;
  assign mem_in_done = (r_state == DONE);
  assign mem_busy    = (r_state != IDLE);
  assign mem_err     = r_err;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, address width matching the buffer-stage memory address.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter DEPTH, default 32, number of words, 1..2^ADDR_W.
REQ-004 SHALL have parameter LATENCY, default 2, request-accept to completion in cycles, minimum 1.
REQ-005 SHALL use one clock, clk, and an asynchronous active-high reset, rst.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port out_1_mem_addr, input, ADDR_W, request word address.
REQ-009 SHALL have port out_1_mem_data, input, DATA_W, store data.
REQ-010 SHALL have port out_load_flag, input, 1, load request.
REQ-011 SHALL have port out_store_flag, input, 1, store request.
REQ-012 SHALL have port load_data, output, DATA_W, load result.
REQ-013 SHALL have port mem_in_done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port mem_busy, output, 1, high while a request is outstanding.
REQ-015 SHALL have port mem_err, output, 1, one-cycle error pulse.

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, WAIT and DONE.
REQ-017 In IDLE, a request SHALL be accepted at a clock edge when exactly one of out_load_flag or out_store_flag is high; address and data SHALL be captured at that edge, the latency counter SHALL load LATENCY-1, and the FSM SHALL move to WAIT, or directly to DONE when LATENCY=1.
REQ-018 In IDLE, when both flags are high, the request SHALL NOT be accepted, no array write SHALL occur, the FSM SHALL stay in IDLE, and mem_err SHALL pulse for 1 cycle.
REQ-019 In WAIT, the counter SHALL decrement each cycle; on the edge where it reaches 0 the FSM SHALL move to DONE.
REQ-020 In DONE, mem_in_done SHALL be 1 for exactly one cycle; the FSM SHALL return to IDLE at the next edge regardless of the flags.
REQ-021 Completion SHALL occur exactly LATENCY cycles after the accept edge.
REQ-022 A store SHALL write the captured data to the array at the accept edge.
REQ-023 A load SHALL read the array at the edge entering DONE; load_data SHALL be valid while mem_in_done is high and SHALL hold until the next load completes.
REQ-024 A store SHALL NOT change load_data.
REQ-025 Flag or address changes in WAIT or DONE SHALL be ignored; there SHALL be no queueing.
REQ-026 The requester SHALL keep flags high until mem_in_done and drop them the cycle after; flags still high in IDLE SHALL be treated as a new request.
REQ-027 mem_busy SHALL be 1 in WAIT and DONE, and 0 in IDLE.
REQ-028 Back-to-back throughput SHALL be one request per LATENCY+1 cycles.

Reset
REQ-029 On rst high, asynchronously: FSM SHALL go to IDLE, counter to 0, load_data to 0, mem_in_done to 0, mem_busy to 0, mem_err to 0, and all array words to 0.
REQ-030 Reset mid-request SHALL abandon the request with no completion pulse; a store already accepted SHALL be cleared by the array reset.
REQ-031 The first request SHALL be accepted at the first rising edge with rst low.

Configuration
REQ-032 Macro DATA_MEM_RESPONDER_RANGE_CHECK_EN SHALL select out-of-range address handling.
REQ-033 With DATA_MEM_RESPONDER_RANGE_CHECK_EN defined, an accepted request with address >= DEPTH SHALL complete normally in timing, SHALL NOT write the array, SHALL return load_data=0 for a load, and SHALL pulse mem_err together with mem_in_done.
REQ-034 Without DATA_MEM_RESPONDER_RANGE_CHECK_EN, the address SHALL be used modulo DEPTH and mem_err SHALL pulse only for the both-flags case.

Verification
REQ-035 With LATENCY=2: store addr 3, data 0xDEADBEEF accepted at T -> mem_in_done=1 at T+2 only, mem_busy=1 at T+1..T+2, load_data unchanged.
REQ-036 Load addr 3 after REQ-035 -> mem_in_done at accept+2 with load_data=0xDEADBEEF, held until the next load.
REQ-037 Both flags high in IDLE -> mem_err pulse for 1 cycle, no mem_in_done, word unchanged on a later load.
REQ-038 Store 0x1 to addr 5, then flags held high through DONE -> one completion only; a second request is accepted only from the IDLE cycle.
REQ-039 rst asserted at T+1 of a load -> no mem_in_done, all outputs 0, load of any addr returns 0.
REQ-040 DEPTH=16 with DATA_MEM_RESPONDER_RANGE_CHECK_EN: load addr 20 -> load_data=0, mem_err with mem_in_done; without the macro, store then load addr 20 -> returns word 4.
